cpu_run_ctrl: RTL
=================

// Module: cpu_run_ctrl
// PURPOSE
//  Top-level sequencer for the 16-bit CPU. After reset it holds the core stalled, then loads a
//  program image into instruction memory port 2 from a valid/ready word stream. It reloads the
//  PC to the image base and releases the core (free-run or single-step). It halts the core when
//  an STP opcode is fetched. It drives the core's global run enable and PC load; the decoder
//  remains the per-instruction controller.
// PARAMETERS
//  ADDR_W      16       instruction memory address width
//  DATA_W      16       instruction word width
//  LOAD_BASE   16'h0000 first load address and PC restart value
//  STP_OPC     5'b11111 opcode (instr[15:11]) that halts the core
// PORTS
//  clk         in   1       single clock; all state on rising edge
//  rst_n       in   1       synchronous, active-low reset
//  ld_start    in   1       pulse: begin load session
//  ld_len      in   ADDR_W  words to load, sampled with ld_start
//  ld_data     in   DATA_W  load word
//  ld_valid    in   1       ld_data valid
//  ld_ready    out  1       controller accepts ld_data
//  imem_addr   out  ADDR_W  instruction memory port-2 write address
//  imem_wdata  out  DATA_W  instruction memory port-2 write data
//  imem_wen    out  1       instruction memory port-2 write enable
//  instr       in   DATA_W  instruction currently presented to the decoder
//  step_mode   in   1       1 = single-step, 0 = free-run
//  step_req    in   1       pulse: execute one instruction (step_mode only)
//  resume      in   1       pulse: (re)start execution from LOAD_BASE
//  cpu_run     out  1       global enable gating pc/reg/mem writes in the core
//  pc_load     out  1       one-cycle PC reload strobe
//  pc_value    out  ADDR_W  PC reload value (always LOAD_BASE)
//  ld_done     out  1       one-cycle pulse: load session complete
//  halted      out  1       core stopped on STP
//  state       out  2       IDLE=00 LOAD=01 RUN=10 HALT=11
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge):
//  - state=IDLE; every output 0 except pc_value=LOAD_BASE.
//  - Load counter cleared; any pending write dropped.
//  - Applies mid-load and mid-run alike.
//  Priority on simultaneous inputs: rst_n > ld_start > resume > step_req.
//  IDLE:
//  - ld_start with ld_len!=0 -> LOAD.
//  - ld_start with ld_len==0 -> RUN with pc_load; ld_done pulses in the same cycle.
//  - resume -> RUN with pc_load (runs the existing image).
//  LOAD:
//  - ld_ready=1 until the last word is accepted.
//  - Handshake = ld_valid & ld_ready.
//  - The write is registered: on the cycle after a handshake, imem_wen=1,
//    imem_addr=LOAD_BASE+count (mod 2^ADDR_W), imem_wdata=captured word; count then increments.
//  - Handshake on word ld_len-1: ld_ready=0 the next cycle and state -> RUN. That same cycle
//    carries the last write and pulses ld_done=1 and pc_load=1.
//  - ld_start in LOAD is ignored. ld_valid with ld_ready=0 is ignored (no write).
//  RUN:
//  - Free-run: cpu_run=1 every cycle after entry.
//  - Step mode: cpu_run=1 for exactly one cycle per step_req. step_req while cpu_run=1 is ignored.
//  - instr[15:11]==STP_OPC while cpu_run=1 -> HALT next cycle; cpu_run=0 from that cycle.
//  - ld_start -> LOAD; cpu_run=0 next cycle.
//  HALT:
//  - halted=1, cpu_run=0.
//  - resume -> RUN with pc_load (the PC is held on STP, so no plain continue).
//  - ld_start -> LOAD.
//  pc_load and cpu_run are never 1 in the same cycle; cpu_run rises the cycle after pc_load.
//  ld_len=65535 and address wrap past 16'hFFFF wrap modulo 2^ADDR_W without error.
// TESTING
//  1. rst_n=0 for 2 cycles mid-LOAD -> state=00, imem_wen=0, ld_ready=0, cpu_run=0 next cycle.
//  2. ld_start, ld_len=3, words A1,B2,C3 with valid gaps -> writes 0/A1,1/B2,2/C3;
//     ld_done and pc_load on the write of C3; cpu_run=1 the next cycle.
//  3. RUN free-run, instr=16'hF800 -> HALT, halted=1, cpu_run=0 the next cycle;
//     resume -> pc_load, then cpu_run=1.
//  4. step_mode=1, three step_req pulses 5 cycles apart -> exactly three single-cycle cpu_run pulses.
//  5. ld_start and resume in the same cycle in HALT -> LOAD entered, no pc_load.
//  6. LOAD_BASE=16'hFFFE, ld_len=4 -> write addresses FFFE, FFFF, 0000, 0001.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: top-level run sequencer for the 16-bit CPU.
// Loads a program image through instruction-memory port 2 from a valid/ready
// word stream, reloads the PC to LOAD_BASE, then runs the core free or in
// single steps until an STP opcode is fetched.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | after reset; core stalled, waiting for ld_start or resume
//   LOAD  | accepting image words and writing them to instruction memory
//   RUN   | core enabled (free-run) or gated one cycle per step_req
//   HALT  | STP fetched; core stopped until resume or a new load
module cpu_run_ctrl #(
  parameter int unsigned            ADDR_W    = 16,
  parameter int unsigned            DATA_W    = 16,
  parameter logic [ADDR_W-1:0]      LOAD_BASE = '0,
  parameter logic [4:0]             STP_OPC   = 5'b11111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_len,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              imem_wen,
  input  logic [DATA_W-1:0] instr,
  input  logic              step_mode,
  input  logic              step_req,
  input  logic              resume,
  output logic              cpu_run,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_value,
  output logic              ld_done,
  output logic              halted,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_HALT = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ld_ready_q, ld_ready_d;
  logic                imem_wen_q, imem_wen_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [DATA_W-1:0]   imem_wdata_q, imem_wdata_d;
  logic                cpu_run_q, cpu_run_d;
  logic                pc_load_q, pc_load_d;
  logic                ld_done_q, ld_done_d;
  logic                halted_q, halted_d;

  logic                hs;
  logic                is_stp;

  assign hs = ld_valid & ld_ready_q;
  // Compare the whole shifted word so the opcode field is matched in place
  // without leaving the operand bits dangling.
  assign is_stp = ((instr >> (DATA_W - 5)) == {{(DATA_W-5){1'b0}}, STP_OPC});

  // Next-state and next-output decode; ld_start outranks resume outranks step_req.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    ld_ready_d   = ld_ready_q;
    imem_wen_d   = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_run_d    = 1'b0;
    pc_load_d    = 1'b0;
    ld_done_d    = 1'b0;

    if (state_q == S_LOAD) begin
      if (hs) begin
        imem_wen_d   = 1'b1;
        imem_addr_d  = LOAD_BASE + cnt_q;
        imem_wdata_d = ld_data;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == len_q - 1'b1) begin
          ld_ready_d = 1'b0;
          state_d    = S_RUN;
          ld_done_d  = 1'b1;
          pc_load_d  = 1'b1;
        end
      end
    end else if (ld_start) begin
      cnt_d = '0;
      len_d = ld_len;
      if (ld_len == '0) begin
        // Empty image: the session completes immediately and runs what is there.
        state_d   = S_RUN;
        pc_load_d = 1'b1;
        ld_done_d = 1'b1;
      end else begin
        state_d    = S_LOAD;
        ld_ready_d = 1'b1;
      end
    end else if (resume && (state_q != S_RUN)) begin
      // STP leaves the PC parked on itself, so restart is always a reload.
      state_d   = S_RUN;
      pc_load_d = 1'b1;
    end else if (state_q == S_RUN) begin
      if (cpu_run_q && is_stp) begin
        state_d = S_HALT;
      end else if (!step_mode) begin
        cpu_run_d = 1'b1;
      end else begin
        cpu_run_d = step_req & ~cpu_run_q;
      end
    end

    halted_d = (state_d == S_HALT);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      ld_ready_q   <= 1'b0;
      imem_wen_q   <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_run_q    <= 1'b0;
      pc_load_q    <= 1'b0;
      ld_done_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      ld_ready_q   <= ld_ready_d;
      imem_wen_q   <= imem_wen_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_run_q    <= cpu_run_d;
      pc_load_q    <= pc_load_d;
      ld_done_q    <= ld_done_d;
      halted_q     <= halted_d;
    end
  end

  assign ld_ready   = ld_ready_q;
  assign imem_wen   = imem_wen_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_run    = cpu_run_q;
  assign pc_load    = pc_load_q;
  assign pc_value   = LOAD_BASE;
  assign ld_done    = ld_done_q;
  assign halted     = halted_q;
  assign state      = state_q;

endmodule
